// File: rtl/moving_average_pow2.sv
// moving_average_pow2
//   Running-sum boxcar filter over the last N = 2^win_sel unsigned samples.
//   N is selectable at runtime up to D = 2^MAX_LOG2_WIN. The window sum is
//   kept incrementally: each new sample is added and the sample that falls
//   out of the window (read from a circular history buffer) is subtracted.
//   The divide by N is a right shift, with optional round-half-up.
//
// Ports
//   clk        : system clock, all logic on rising edge
//   rst_n      : synchronous reset, active low
//   ena        : 0 ignores strobes and freezes the strobe history
//   win_sel    : log2 of the window; values above MAX_LOG2_WIN clamp
//   strobe_in  : sample strobe (rising-edge level or 1-cycle pulse, per STROBE_EDGE)
//   data_in    : sample, captured on the edge where the strobe is detected
//   data_out   : filtered result (registered)
//   strobe_out : 1-cycle pulse when data_out has been updated
//   filled     : 1 once N samples have been accumulated since reset/flush
module moving_average_pow2 #(
  parameter int DATA_W       = 10,
  parameter int MAX_LOG2_WIN = 5,
  parameter int ROUND        = 1,
  parameter int STROBE_EDGE  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic [$clog2(MAX_LOG2_WIN+1)-1:0]     win_sel,
  input  logic                                  strobe_in,
  input  logic [DATA_W-1:0]                     data_in,
  output logic [DATA_W-1:0]                     data_out,
  output logic                                  strobe_out,
  output logic                                  filled
);

  localparam int D     = 1 << MAX_LOG2_WIN;
  localparam int WS_W  = $clog2(MAX_LOG2_WIN + 1);
  localparam int PTR_W = MAX_LOG2_WIN;
  localparam int CNT_W = MAX_LOG2_WIN + 1;
  localparam int SUM_W = DATA_W + MAX_LOG2_WIN;

  // Divide the window sum by 2^win. With rounding enabled, half an LSB of
  // the result (N/2) is added first. sum + N/2 < N * 2^DATA_W, so the
  // shifted result always fits in DATA_W bits.
  function automatic logic [DATA_W-1:0] div_round(input logic [SUM_W-1:0] s,
                                                  input logic [WS_W-1:0]  win);
    logic [SUM_W:0] one;
    logic [SUM_W:0] half;
    logic [SUM_W:0] t;
    one  = (SUM_W+1)'(1);
    half = (one << win) >> 1;
    if (ROUND == 0) half = '0;
    t = {1'b0, s} + half;
    t = t >> win;
    return t[DATA_W-1:0];
  endfunction

  logic                  strobe_q;
  logic                  hit;
  logic [WS_W-1:0]       win_q;
  logic [WS_W-1:0]       win_clamp;
  logic                  flush;
  logic [CNT_W-1:0]      n_win;

  logic [DATA_W-1:0]     x_p0;
  logic                  vld_p0;

  logic [DATA_W-1:0]     buf_mem [D];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_idx;
  logic [DATA_W-1:0]     old_p1;
  logic [SUM_W-1:0]      sum_p1;
  logic [SUM_W-1:0]      sum_next;
  logic [CNT_W-1:0]      fill_cnt_p1;
  logic                  vld_p1;

  always_comb begin
    hit = (STROBE_EDGE != 0) ? (strobe_in & ~strobe_q & ena) : (strobe_in & ena);
  end

  always_comb begin
    win_clamp = (win_sel > WS_W'(MAX_LOG2_WIN)) ? WS_W'(MAX_LOG2_WIN) : win_sel;
    flush     = (win_clamp != win_q);
    n_win     = CNT_W'(1) << win_q;
  end

  // Oldest sample of the window sits N slots behind the write pointer. For
  // N = D this is the slot being overwritten this cycle; the array is read
  // before the write lands, so the old value is seen. Until N samples have
  // been seen the missing samples count as zero.
  always_comb begin
    rd_idx   = wr_ptr - n_win[PTR_W-1:0];
    old_p1   = (fill_cnt_p1 >= n_win) ? buf_mem[rd_idx] : '0;
    sum_next = sum_p1 + SUM_W'(x_p0) - SUM_W'(old_p1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else if (ena) begin
      strobe_q <= strobe_in;
    end
  end

  // ---- stage p0: capture sample ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= hit;
  end

  always_ff @(posedge clk) begin
    if (hit) x_p0 <= data_in;
  end

  // ---- stage p1: update history buffer and running sum ----
  always_ff @(posedge clk) begin
    if (vld_p0) buf_mem[wr_ptr] <= x_p0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1      <= '0;
      fill_cnt_p1 <= '0;
      wr_ptr      <= '0;
      vld_p1      <= 1'b0;
      win_q       <= '0;
    end else begin
      win_q  <= win_clamp;
      vld_p1 <= vld_p0;
      if (vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (flush) begin
        // Window changed: restart accumulation; a sample in flight becomes
        // the first sample of the new window.
        sum_p1      <= vld_p0 ? SUM_W'(x_p0) : '0;
        fill_cnt_p1 <= vld_p0 ? CNT_W'(1) : '0;
      end else if (vld_p0) begin
        sum_p1 <= sum_next;
        if (fill_cnt_p1 != CNT_W'(D)) fill_cnt_p1 <= fill_cnt_p1 + CNT_W'(1);
      end
    end
  end

  // ---- stage p2: divide and present result ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      strobe_out <= 1'b0;
      filled     <= 1'b0;
    end else begin
      strobe_out <= vld_p1;
      if (vld_p1) begin
        data_out <= div_round(sum_p1, win_q);
        filled   <= (fill_cnt_p1 >= n_win);
      end
      if (flush) filled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average_pow2.sv
module tb_moving_average_pow2;

  localparam int DATA_W = 10;
  localparam int MAXW   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic [2:0]        win_sel;
  logic              s_e, s_p;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] e_do, p_do, t_do;
  logic              e_so, p_so, t_so;
  logic              e_fl, p_fl, t_fl;

  always #5 clk = ~clk;

  // Edge-strobe, rounding
  moving_average_pow2 #(.DATA_W(DATA_W), .MAX_LOG2_WIN(MAXW), .ROUND(1), .STROBE_EDGE(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .ena(ena), .win_sel(win_sel), .strobe_in(s_e),
    .data_in(data_in), .data_out(e_do), .strobe_out(e_so), .filled(e_fl));
  // Pulse-strobe, rounding
  moving_average_pow2 #(.DATA_W(DATA_W), .MAX_LOG2_WIN(MAXW), .ROUND(1), .STROBE_EDGE(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .ena(ena), .win_sel(win_sel), .strobe_in(s_p),
    .data_in(data_in), .data_out(p_do), .strobe_out(p_so), .filled(p_fl));
  // Pulse-strobe, truncating
  moving_average_pow2 #(.DATA_W(DATA_W), .MAX_LOG2_WIN(MAXW), .ROUND(0), .STROBE_EDGE(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .ena(ena), .win_sel(win_sel), .strobe_in(s_p),
    .data_in(data_in), .data_out(t_do), .strobe_out(t_so), .filled(t_fl));

  int n_checks = 0;
  int n_errors = 0;

  int hist_e[$];
  int hist_p[$];
  int exp_e_d[$], exp_e_f[$];
  int exp_p_d[$], exp_p_f[$];
  int exp_t_d[$], exp_t_f[$];
  int cnt_e = 0, cnt_p = 0, run_p = 0, max_run_p = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wclamp();
    return (int'(win_sel) > MAXW) ? MAXW : int'(win_sel);
  endfunction

  // Scoreboard: compare each strobe_out against the oldest expected entry
  always @(negedge clk) begin
    if (rst_n) begin
      if (e_so) begin
        cnt_e++;
        if (exp_e_d.size() == 0) check("e_unexpected_strobe", int'(e_so), 0);
        else begin
          check("e_data", int'(e_do), exp_e_d.pop_front());
          check("e_filled", int'(e_fl), exp_e_f.pop_front());
        end
      end
      if (p_so) begin
        cnt_p++;
        run_p++;
        if (run_p > max_run_p) max_run_p = run_p;
        if (exp_p_d.size() == 0) check("p_unexpected_strobe", int'(p_so), 0);
        else begin
          check("p_data", int'(p_do), exp_p_d.pop_front());
          check("p_filled", int'(p_fl), exp_p_f.pop_front());
        end
      end else begin
        run_p = 0;
      end
      if (t_so) begin
        if (exp_t_d.size() == 0) check("t_unexpected_strobe", int'(t_so), 0);
        else begin
          check("t_data", int'(t_do), exp_t_d.pop_front());
          check("t_filled", int'(t_fl), exp_t_f.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_e = 1'b0;
    s_p = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist_e.delete();
    hist_p.delete();
    check("rst_e_data", int'(e_do), 0);
    check("rst_e_strobe", int'(e_so), 0);
    check("rst_e_filled", int'(e_fl), 0);
    check("rst_p_data", int'(p_do), 0);
    check("rst_p_strobe", int'(p_so), 0);
    check("rst_p_filled", int'(p_fl), 0);
    idle(2);
  endtask

  // One sample on the edge-strobe instance (strobe high one cycle, low one)
  task automatic edge_sample(input int x);
    int w, n, m, s;
    w = wclamp();
    n = 1 << w;
    hist_e.push_back(x);
    if (hist_e.size() > 32) void'(hist_e.pop_front());
    m = (hist_e.size() < n) ? hist_e.size() : n;
    s = 0;
    for (int i = 0; i < m; i++) s += hist_e[hist_e.size() - 1 - i];
    exp_e_d.push_back((s + n / 2) >> w);
    exp_e_f.push_back((hist_e.size() >= n) ? 1 : 0);
    data_in = x[DATA_W-1:0];
    s_e = 1'b1;
    @(posedge clk);
    #1;
    s_e = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One cycle of pulse strobe; consecutive calls keep strobe_in high
  task automatic pulse_drive(input int x);
    int w, n, m, s;
    w = wclamp();
    n = 1 << w;
    hist_p.push_back(x);
    if (hist_p.size() > 32) void'(hist_p.pop_front());
    m = (hist_p.size() < n) ? hist_p.size() : n;
    s = 0;
    for (int i = 0; i < m; i++) s += hist_p[hist_p.size() - 1 - i];
    exp_p_d.push_back((s + n / 2) >> w);
    exp_p_f.push_back((hist_p.size() >= n) ? 1 : 0);
    exp_t_d.push_back(s >> w);
    exp_t_f.push_back((hist_p.size() >= n) ? 1 : 0);
    data_in = x[DATA_W-1:0];
    s_p = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    ena = 1'b1;
    win_sel = 3'd2;
    s_e = 1'b0;
    s_p = 1'b0;
    data_in = '0;
    idle(2);

    // N=4 ramp: 250,500,750,1000,1000
    do_reset();
    for (int i = 0; i < 5; i++) edge_sample(1000);
    idle(4);

    // Rounding: 3,0 with N=4 -> 1,1 rounded, 0,0 truncated
    pulse_drive(3);
    pulse_drive(0);
    s_p = 1'b0;
    idle(4);

    // Window change flush: steady N=4 at 500, then N=2
    do_reset();
    for (int i = 0; i < 5; i++) edge_sample(500);
    idle(4);
    win_sel = 3'd1;
    idle(2);
    check("flush_filled_drop", int'(e_fl), 0);
    hist_e.delete();
    hist_p.delete();
    edge_sample(500);
    edge_sample(500);
    idle(4);

    // Back-to-back pulses, N=2, data 1..8
    do_reset();
    c0 = cnt_p;
    for (int i = 1; i <= 8; i++) pulse_drive(i);
    s_p = 1'b0;
    idle(4);
    check("burst_count", cnt_p - c0, 8);
    check("burst_back_to_back", max_run_p, 8);

    // N=32: 40 full-scale samples then 32 zeros
    win_sel = 3'd5;
    do_reset();
    for (int i = 0; i < 40; i++) edge_sample(1023);
    for (int i = 0; i < 32; i++) edge_sample(0);
    idle(4);

    // ena=0: strobe ignored
    c0 = cnt_e;
    ena = 1'b0;
    data_in = 10'd99;
    s_e = 1'b1;
    idle(1);
    s_e = 1'b0;
    idle(1);
    ena = 1'b1;
    idle(4);
    check("ena_low_no_output", cnt_e - c0, 0);

    // Reset with a sample in flight, then win_sel=7 clamps to N=32
    win_sel = 3'd7;
    data_in = 10'd77;
    s_e = 1'b1;
    idle(1);
    s_e = 1'b0;
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    hist_e.delete();
    hist_p.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_strobe", int'(e_so), 0);
      check("midrst_data", int'(e_do), 0);
      check("midrst_filled", int'(e_fl), 0);
    end
    idle(1);
    edge_sample(1023);
    edge_sample(1023);
    idle(4);

    check("e_queue_drained", exp_e_d.size(), 0);
    check("p_queue_drained", exp_p_d.size(), 0);
    check("t_queue_drained", exp_t_d.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
